// File: rtl/fifo_vec_reader_if.sv
// Signal bundle for fifo_vec_reader: command/status, FIFO read port and packed-vector stream.
// The master side is the reader itself; the slave side is whatever drives it.
interface fifo_vec_reader_if #(
  parameter int LANES     = 4,
  parameter int NBITS     = 16,
  parameter int CNT_WIDTH = 8
);
  logic                   start;
  logic [CNT_WIDTH-1:0]   num_vec;
  logic                   busy;
  logic                   done;
  logic                   fifo_empty;
  logic [NBITS-1:0]       fifo_q;
  logic                   fifo_ren;
  logic [LANES*NBITS-1:0] out_vec;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  start, num_vec, fifo_empty, fifo_q, out_ready,
    output busy, done, fifo_ren, out_vec, out_valid
  );

  modport slave (
    output start, num_vec, fifo_empty, fifo_q, out_ready,
    input  busy, done, fifo_ren, out_vec, out_valid
  );
endinterface

// File: rtl/fifo_vec_reader.sv
// Pops LANES words from a FIFO, packs them lane 0 first into one vector and hands it
// downstream on valid/ready, repeating num_vec times per start command.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// FILL  | popping words into lanes of out_vec, stalls while the FIFO is empty
// HOLD  | full vector presented with out_valid=1 until out_ready
module fifo_vec_reader #(
  parameter int LANES     = 4,
  parameter int NBITS     = 16,
  parameter int CNT_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  fifo_vec_reader_if.master bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [LW-1:0]          lane_cnt, lane_cnt_nxt;
  logic [CNT_WIDTH-1:0]   vec_cnt, vec_cnt_nxt;
  logic [CNT_WIDTH-1:0]   num_lat, num_lat_nxt;
  logic [LANES*NBITS-1:0] vec, vec_nxt;
  logic                   valid, valid_nxt;
  logic                   done_r, done_nxt;
  logic                   pop;

  assign pop = (state == FILL) && !bus.fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lane_cnt <= '0;
      vec_cnt  <= '0;
      num_lat  <= '0;
      vec      <= '0;
      valid    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      lane_cnt <= lane_cnt_nxt;
      vec_cnt  <= vec_cnt_nxt;
      num_lat  <= num_lat_nxt;
      vec      <= vec_nxt;
      valid    <= valid_nxt;
      done_r   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lane_cnt_nxt = lane_cnt;
    vec_cnt_nxt  = vec_cnt;
    num_lat_nxt  = num_lat;
    vec_nxt      = vec;
    valid_nxt    = valid;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_vec != '0) begin
            num_lat_nxt  = bus.num_vec;
            lane_cnt_nxt = '0;
            vec_cnt_nxt  = '0;
            state_nxt    = FILL;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end

      FILL: begin
        if (pop) begin
          vec_nxt[int'(lane_cnt)*NBITS +: NBITS] = bus.fifo_q;
          // Explicit wrap so a non-power-of-2 LANES never walks past the last lane.
          if (lane_cnt == LAST_LANE) begin
            lane_cnt_nxt = '0;
            valid_nxt    = 1'b1;
            state_nxt    = HOLD;
          end else begin
            lane_cnt_nxt = lane_cnt + LW'(1);
          end
        end
      end

      HOLD: begin
        if (valid && bus.out_ready) begin
          valid_nxt = 1'b0;
          if (vec_cnt == num_lat - CNT_WIDTH'(1)) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            vec_cnt_nxt = vec_cnt + CNT_WIDTH'(1);
            state_nxt   = FILL;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.fifo_ren  = pop;
  assign bus.out_vec   = vec;
  assign bus.out_valid = valid;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
endmodule

// File: tb/tb_fifo_vec_reader.sv
// Bench for fifo_vec_reader: a queue-based FIFO plus a transaction-level model of the
// reader, compared every cycle, with directed scenarios and a randomized phase.
module tb_fifo_vec_reader;
  localparam int LANES = 4;
  localparam int NBITS = 16;
  localparam int CW    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_vec_reader_if #(.LANES(LANES), .NBITS(NBITS), .CNT_WIDTH(CW)) bus();

  fifo_vec_reader #(.LANES(LANES), .NBITS(NBITS), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [NBITS-1:0] fq[$];
  bit               auto_fill = 0;
  logic [NBITS-1:0] fill_word = 16'h8000;

  // Model: active command, whether a full vector is held, vectors still owed,
  // words gathered into the vector being built, and the visible vector contents.
  bit               m_active, m_hold, m_done;
  int               m_left, m_nwords;
  logic [63:0]      m_vec;

  int pops, hs, dones;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_q     = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [NBITS-1:0] w);
    fq.push_back(w);
    refresh();
  endtask

  task automatic model_reset();
    m_active = 0; m_hold = 0; m_done = 0;
    m_left = 0; m_nwords = 0; m_vec = '0;
  endtask

  // One clock: check outputs at negedge, then apply this cycle's effects after the edge.
  task automatic cycle();
    bit ren;
    logic [NBITS-1:0] w;
    @(negedge clk);
    ren = m_active && !m_hold && (fq.size() > 0);
    chk("fifo_ren", 64'(bus.fifo_ren), 64'(ren));
    chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
    chk("busy", 64'(bus.busy), 64'(m_active));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("out_vec", bus.out_vec, m_vec);
    if (bus.fifo_ren) pops++;
    if (bus.out_valid && bus.out_ready) hs++;
    if (bus.done) dones++;
    @(posedge clk);
    #1;
    w = (fq.size() > 0) ? fq[0] : '0;
    if (rst) begin
      model_reset();
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (bus.start) begin
          if (bus.num_vec != 0) begin
            m_active = 1; m_left = int'(bus.num_vec); m_nwords = 0;
          end else begin
            m_done = 1;
          end
        end
      end else if (!m_hold) begin
        if (ren) begin
          m_vec[m_nwords*NBITS +: NBITS] = w;
          m_nwords++;
          if (m_nwords == LANES) begin
            m_hold = 1; m_nwords = 0;
          end
        end
      end else if (bus.out_ready) begin
        m_hold = 0;
        m_left--;
        if (m_left == 0) begin
          m_active = 0; m_done = 1;
        end
      end
    end
    if (ren) void'(fq.pop_front());
    if (auto_fill) begin
      while (fq.size() < 8) begin
        fq.push_back(fill_word);
        fill_word++;
      end
    end
    refresh();
  endtask

  task automatic wait_valid(input int lim, input string name);
    int k = 0;
    while (!bus.out_valid && k < lim) begin
      cycle();
      k++;
    end
    chk(name, 64'(bus.out_valid), 64'd1);
  endtask

  task automatic wait_idle(input int lim, input string name);
    int k = 0;
    while (bus.busy && k < lim) begin
      cycle();
      k++;
    end
    chk(name, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_vec = '0;
    bus.out_ready = 1'b0;
    refresh();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_vec", bus.out_vec, 64'd0);
    chk("rst_ren", 64'(bus.fifo_ren), 64'd0);
    rst = 1'b0;
    cycle();

    // Basic vector
    for (int i = 1; i <= 4; i++) push(16'(i));
    bus.out_ready = 1'b1;
    bus.start = 1'b1; bus.num_vec = 8'd1;
    cycle();
    bus.start = 1'b0;
    pops = 0;
    wait_valid(20, "basic_valid_timeout");
    chk("basic_pops", 64'(pops), 64'd4);
    chk("basic_vec", bus.out_vec, 64'h0004_0003_0002_0001);
    cycle();
    chk("basic_done", 64'(bus.done), 64'd1);
    chk("basic_busy", 64'(bus.busy), 64'd0);
    cycle();
    chk("basic_done_once", 64'(bus.done), 64'd0);

    // Starved FIFO: one word every 3 cycles
    pops = 0;
    bus.start = 1'b1; bus.num_vec = 8'd1;
    cycle();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(16'(16'h0100 + i));
      cycle();
      if (i < 3) repeat (2) cycle();
    end
    chk("starve_valid", 64'(bus.out_valid), 64'd1);
    chk("starve_vec", bus.out_vec, 64'h0103_0102_0101_0100);
    chk("starve_pops", 64'(pops), 64'd4);
    cycle();
    chk("starve_done", 64'(bus.done), 64'd1);
    cycle();

    // Backpressure
    for (int i = 0; i < 8; i++) push(16'(16'h0010 + i));
    bus.out_ready = 1'b0;
    bus.start = 1'b1; bus.num_vec = 8'd2;
    cycle();
    bus.start = 1'b0;
    wait_valid(20, "bp_valid1_timeout");
    chk("bp_vec1", bus.out_vec, 64'h0013_0012_0011_0010);
    p0 = pops;
    repeat (5) cycle();
    chk("bp_stall_vec", bus.out_vec, 64'h0013_0012_0011_0010);
    chk("bp_stall_pops", 64'(pops - p0), 64'd0);
    chk("bp_stall_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    cycle();
    wait_valid(20, "bp_valid2_timeout");
    chk("bp_vec2", bus.out_vec, 64'h0017_0016_0015_0014);
    cycle();
    chk("bp_done", 64'(bus.done), 64'd1);
    cycle();

    // Zero-count start
    p0 = pops;
    bus.start = 1'b1; bus.num_vec = 8'd0;
    cycle();
    bus.start = 1'b0;
    chk("zero_done", 64'(bus.done), 64'd1);
    chk("zero_busy", 64'(bus.busy), 64'd0);
    cycle();
    chk("zero_done_once", 64'(bus.done), 64'd0);
    chk("zero_pops", 64'(pops - p0), 64'd0);

    // Start while busy is ignored
    for (int i = 0; i < 8; i++) push(16'(16'h0020 + i));
    hs = 0; pops = 0; dones = 0;
    bus.start = 1'b1; bus.num_vec = 8'd2;
    cycle();
    bus.start = 1'b0;
    cycle();
    bus.start = 1'b1; bus.num_vec = 8'd7;
    cycle();
    bus.start = 1'b0; bus.num_vec = 8'd0;
    wait_idle(60, "busy_idle_timeout");
    chk("busy_done", 64'(bus.done), 64'd1);
    cycle();
    chk("busy_hs", 64'(hs), 64'd2);
    chk("busy_pops", 64'(pops), 64'd8);
    chk("busy_dones", 64'(dones), 64'd1);
    chk("busy_fifo_left", 64'(fq.size()), 64'd0);

    // Reset mid-FILL; the pop in the reset cycle itself is also lost
    for (int i = 0; i < 8; i++) push(16'(16'h0030 + i));
    bus.start = 1'b1; bus.num_vec = 8'd1;
    cycle();
    bus.start = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_vec", bus.out_vec, 64'd0);
    chk("mid_rst_ren", 64'(bus.fifo_ren), 64'd0);
    bus.start = 1'b1; bus.num_vec = 8'd1;
    cycle();
    bus.start = 1'b0;
    wait_valid(20, "after_rst_timeout");
    chk("after_rst_vec", bus.out_vec, 64'h0036_0035_0034_0033);
    cycle();
    cycle();

    // Counter extent: 255 vectors from a never-empty FIFO
    auto_fill = 1;
    while (fq.size() < 8) begin
      fq.push_back(fill_word);
      fill_word++;
    end
    refresh();
    hs = 0; pops = 0; dones = 0;
    bus.start = 1'b1; bus.num_vec = 8'd255;
    cycle();
    bus.start = 1'b0;
    wait_idle(2000, "ext_idle_timeout");
    chk("ext_done", 64'(bus.done), 64'd1);
    cycle();
    chk("ext_hs", 64'(hs), 64'd255);
    chk("ext_pops", 64'(pops), 64'd1020);
    chk("ext_dones", 64'(dones), 64'd1);
    chk("ext_busy", 64'(bus.busy), 64'd0);
    auto_fill = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.start     = ($urandom_range(0, 9) == 0);
      bus.num_vec   = 8'($urandom_range(0, 4));
      rst           = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 1 && fq.size() < 12) push(16'($urandom));
      cycle();
    end
    rst = 1'b0;
    bus.start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_vec_reader.md
Name: fifo_vec_reader

Overview:
- Read-side controller for the NPU's word FIFOs. It pops LANES consecutive NBITS words from a FIFO and packs them into one vector, for example a PE-row operand load.
- It presents each packed vector downstream on a valid/ready handshake and repeats for a programmed number of vectors per start command.
- It connects directly to the FIFO read port (ren, q, empty) and is the consumer counterpart of the FIFO's write-side producers.

Parameters:
- LANES, 4, words packed per output vector (>=2).
- NBITS, 16, bits per FIFO word.
- CNT_WIDTH, 8, width of the num_vec count.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle command pulse; sampled only in IDLE.
- num_vec  input  CNT_WIDTH  number of vectors to produce; latched on an accepted start.
- fifo_empty  input  1  FIFO empty flag.
- fifo_q  input  NBITS  FIFO read data; valid in the same cycle as fifo_ren & ~fifo_empty.
- fifo_ren  output  1  FIFO read enable; the pop occurs at the clock edge ending the cycle.
- out_vec  output  LANES*NBITS  packed vector; lane i at bits [i*NBITS +: NBITS], lane 0 = first word popped.
- out_valid  output  1  out_vec holds a complete vector.
- out_ready  input  1  downstream accepts the vector when out_valid & out_ready.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final vector handshake.

Behaviour:
- Reset (clk edge with rst=1) forces:
  - state=IDLE;
  - out_valid=0, done=0, out_vec=0;
  - lane_cnt=0, vec_cnt=0, num_vec latch=0.
  - rst has priority over every other input. Asserting it mid-operation aborts immediately: a partial vector is discarded, and words already popped are lost (not replayed).
- fifo_ren is combinational: (state==FILL) & ~fifo_empty. It is never asserted in IDLE or HOLD, and never while fifo_empty=1.
- States are IDLE, FILL and HOLD.
- IDLE:
  - busy=0.
  - start=1 with num_vec!=0: latch num_vec, lane_cnt=0, vec_cnt=0, go to FILL.
  - start=1 with num_vec==0: stay in IDLE and pulse done in the next cycle.
- FILL:
  - Each cycle with fifo_ren=1 writes lane[lane_cnt] of out_vec with fifo_q and increments lane_cnt.
  - Cycles with fifo_empty=1 stall and change nothing.
  - On the pop with lane_cnt==LANES-1: lane_cnt returns to 0, out_valid is set to 1, go to HOLD.
  - Minimum fill time is LANES cycles.
- HOLD:
  - out_vec is stable and out_valid=1 until the handshake.
  - On out_valid & out_ready:
    - out_valid goes to 0 next cycle;
    - if vec_cnt==num_vec-1: go to IDLE and pulse done=1 for one cycle;
    - otherwise vec_cnt increments and the state returns to FILL.
  - out_ready while out_valid=0 has no effect.
- Throughput: at most one vector per LANES+1 cycles. FILL and HOLD do not overlap, so no pop happens while a vector is held.
- start while busy=1 is ignored, and the latched num_vec is unaffected.
- out_vec keeps its last value after done. It is meaningful only while out_valid=1; lanes are overwritten progressively during the next FILL.
- Counter widths:
  - vec_cnt is CNT_WIDTH bits, so num_vec up to 2^CNT_WIDTH-1 is supported.
  - lane_cnt is $clog2(LANES) bits; its wrap from LANES-1 back to 0 is explicit, not a natural overflow, so non-power-of-2 LANES works.
- done and busy relationship: done rises in the first IDLE cycle, i.e. the same cycle busy falls.

Test Plan:
- Basic vector: LANES=4, NBITS=16, FIFO preloaded 0x0001..0x0004, start with num_vec=1, out_ready=1.
  - fifo_ren high for exactly 4 consecutive cycles.
  - Then out_valid=1 with out_vec=0x0004_0003_0002_0001.
  - done pulses once the cycle after the handshake; busy=0.
- Starved FIFO: words pushed one every 3 cycles, num_vec=1.
  - fifo_ren is never high while empty=1.
  - The vector completes after the 4th push with the correct lane order, and no word is duplicated or dropped.
- Backpressure: num_vec=2, 8 words preloaded (0x10..0x17), out_ready held low for 5 cycles after the first out_valid.
  - out_vec stays 0x0013_0012_0011_0010 and fifo_ren stays 0 during the stall.
  - The second vector is 0x0017_0016_0015_0014, then done pulses.
- Zero and busy starts:
  - start with num_vec=0: no fifo_ren, done pulses next cycle.
  - start pulsed again while busy with num_vec=7: ignored; exactly the originally programmed vectors are produced.
- Reset mid-FILL: assert rst after 2 of 4 pops.
  - Next cycle: out_valid=0, busy=0, out_vec=0, fifo_ren=0.
  - A new start with num_vec=1 packs the next 4 FIFO words starting at lane 0.
- Counter extent: CNT_WIDTH=8, num_vec=255, out_ready=1, FIFO never empty.
  - Exactly 255 handshakes, 1020 pops, a single done pulse, then IDLE.
